lc4_divmod_seq: RTL and testbench

LC4_DIVMOD_SEQ -- requirements
Module: lc4_divmod_seq

---
 rtl/lc4_alu_pkg.sv | 14 +
 rtl/lc4_divmod_step.sv | 27 ++
 rtl/lc4_divmod_seq.sv | 105 ++++++++++
 tb/tb_lc4_divmod_seq.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc4_alu_pkg.sv
// Shared LC4 ALU definitions: divider FSM states
// and the DIV/MOD opcode constants used by the output mux.
package lc4_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } divmod_state_e;

  localparam logic [2:0] ALU_DIV = 3'd3;
  localparam logic [2:0] ALU_MOD = 3'd4;

endpackage

// File: rtl/lc4_divmod_step.sv
// One restoring-division step: shift, trial subtract, select.
// Ports: rem_i/q_i/dvsr_i in, rem_o/q_o out (all WIDTH bits).
module lc4_divmod_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] q_o
);

  // Full WIDTH+1 shifted remainder so divisors with the
  // MSB set still divide correctly.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           neg;

  assign shifted = {rem_i, q_i[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr_i};
  assign neg     = trial[WIDTH];

  assign rem_o = neg ? shifted[WIDTH-1:0]
                     : trial[WIDTH-1:0];
  assign q_o   = {q_i[WIDTH-2:0], ~neg};

endmodule

// File: rtl/lc4_divmod_seq.sv
// Sequential unsigned DIV/MOD unit, one bit per cycle.
// Ports: req_valid/req_ready/dividend/divisor in-handshake,
// rsp_valid/rsp_ready/quotient/remainder out-handshake, busy.
module lc4_divmod_seq
  import lc4_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  divmod_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_q;

  lc4_divmod_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .q_i   (q_q),
    .dvsr_i(dvsr_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dvsr_q  <= dvsr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    q_d     = q_q;
    dvsr_d  = dvsr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          dvsr_d = divisor;
          cnt_d  = '0;
          rem_d  = '0;
          // Divide by zero yields 0/0 immediately.
          if (divisor == '0) begin
            q_d     = '0;
            state_d = DONE;
          end else begin
            q_d     = dividend;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        q_d   = step_q;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign quotient  = q_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_lc4_divmod_seq.sv
// Directed bench for lc4_divmod_seq.
// Latency counts the accept edge as edge 1.
module tb_lc4_divmod_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lc4_divmod_seq #(
    .WIDTH(16),
    .CNT_W(5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .quotient (quotient),
    .remainder(remainder),
    .busy     (busy)
  );

  // Offer a request at negedge; return #1 after accept edge.
  task automatic issue(input logic [15:0] a,
                       input logic [15:0] b);
    @(negedge clk);
    req_valid = 1'b1;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Bounded wait for rsp_valid; lat=64 on timeout.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_req_ready got=%b want=1", req_ready);
    end
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy got=%b want=0", busy);
    end
    total++;
    if (quotient !== 16'd0 || remainder !== 16'd0) begin
      bad++;
      $display("FAIL rst_results got=%h/%h want=0/0",
               quotient, remainder);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    rsp_ready = 1'b1;
    issue(16'd100, 16'd7);
    total++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL calc_flags got busy=%b rdy=%b want 1 0",
               busy, req_ready);
    end
    wait_rsp(lat);
    total++;
    if (lat !== 17) begin
      bad++;
      $display("FAIL basic_latency got=%0d want=17", lat);
    end
    total++;
    if (quotient !== 16'd14 || remainder !== 16'd2) begin
      bad++;
      $display("FAIL basic_100_7 got=%0d/%0d want=14/2",
               quotient, remainder);
    end
    @(posedge clk);
    #1;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_pulse got v=%b r=%b want 0 1",
               rsp_valid, req_ready);
    end
  endtask

  task automatic test_edges;
    int lat;
    logic [15:0] a [3] = '{16'hFFFF, 16'd3, 16'hFFFF};
    logic [15:0] b [3] = '{16'd1, 16'hFFFF, 16'h8001};
    logic [15:0] eq[3] = '{16'hFFFF, 16'd0, 16'd1};
    logic [15:0] er[3] = '{16'd0, 16'd3, 16'd32766};
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(a[i], b[i]);
      wait_rsp(lat);
      total++;
      if (lat !== 17 || quotient !== eq[i] ||
          remainder !== er[i]) begin
        bad++;
        $display("FAIL edge_%0d got lat=%0d %h/%h want 17 %h/%h",
                 i, lat, quotient, remainder, eq[i], er[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_div_zero;
    int lat;
    rsp_ready = 1'b1;
    issue(16'd1234, 16'd0);
    wait_rsp(lat);
    total++;
    if (lat !== 1) begin
      bad++;
      $display("FAIL div0_latency got=%0d want=1", lat);
    end
    total++;
    if (quotient !== 16'd0 || remainder !== 16'd0) begin
      bad++;
      $display("FAIL div0_results got=%h/%h want=0/0",
               quotient, remainder);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure;
    int lat;
    int errs;
    rsp_ready = 1'b0;
    issue(16'd50, 16'd5);
    wait_rsp(lat);
    total++;
    if (lat !== 17) begin
      bad++;
      $display("FAIL bp_latency got=%0d want=17", lat);
    end
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
          quotient !== 16'd10 || remainder !== 16'd0)
        errs++;
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL bp_hold got %0d bad cycles want 0 (%h/%h)",
               errs, quotient, remainder);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release got v=%b r=%b want 0 1",
               rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int seen;
    rsp_ready = 1'b1;
    issue(16'd1000, 16'd3);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0 ||
        rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_flags got r=%b b=%b v=%b want 1 0 0",
               req_ready, busy, rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL midrst_no_rsp got=%0d want=0", seen);
    end
    issue(16'd9, 16'd2);
    wait_rsp(lat);
    total++;
    if (lat !== 17 || quotient !== 16'd4 ||
        remainder !== 16'd1) begin
      bad++;
      $display("FAIL midrst_9_2 got lat=%0d %0d/%0d want 17 4/1",
               lat, quotient, remainder);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int lat;
    rsp_ready = 1'b1;
    issue(16'd200, 16'd9);
    req_valid = 1'b1;
    dividend  = 16'd77;
    divisor   = 16'd7;
    repeat (3) @(posedge clk);
    #1;
    dividend = 16'd78;
    @(posedge clk);
    #1;
    dividend = 16'd77;
    lat = 5;
    while (rsp_valid !== 1'b1 && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (lat !== 17 || quotient !== 16'd22 ||
        remainder !== 16'd2) begin
      bad++;
      $display("FAIL b2b_first got lat=%0d %0d/%0d want 17 22/2",
               lat, quotient, remainder);
    end
    @(posedge clk);
    #1;
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle got r=%b v=%b want 1 0",
               req_ready, rsp_valid);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    total++;
    if (lat !== 17 || quotient !== 16'd11 ||
        remainder !== 16'd0) begin
      bad++;
      $display("FAIL b2b_second got lat=%0d %0d/%0d want 17 11/0",
               lat, quotient, remainder);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_small;
    int lat;
    rsp_ready = 1'b1;
    issue(16'd5, 16'd9);
    wait_rsp(lat);
    total++;
    if (lat !== 17 || quotient !== 16'd0 ||
        remainder !== 16'd5) begin
      bad++;
      $display("FAIL small_5_9 got lat=%0d %0d/%0d want 17 0/5",
               lat, quotient, remainder);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    test_reset;
    test_basic;
    test_edges;
    test_div_zero;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    test_small;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
